usb_kbd_event_queue: RTL and testbench
======================================

Name: usb_kbd_event_queue

Overview:
- Sits between the USB HID host and the SoC keyboard interface.
- Takes 8-byte HID boot-protocol keyboard reports and compares each accepted report with the previous one.
- Emits one press or release event per changed key into a show-ahead FIFO that the SoC drains.
- Converts level-style reports into an edge-style key stream, so the CPU never sees duplicate or lost transitions while the FIFO has room.

Parameters:
- FIFO_DEPTH, 16, event FIFO depth; must be a power of two, minimum 2.
- REPORT_BYTES, 8, HID report length in bytes; fixed at 8 (boot protocol); any other value is a synthesis error.

Ports:
- clk  input  1  system clock; report inputs are already synchronous to it.
- reset_n_i  input  1  asynchronous active-low reset.
- usb_report_i  input  64  HID report; byte k = bits [8k+7:8k]; byte0 = modifiers, byte1 = reserved, bytes2-7 = key slots.
- usb_report_valid_i  input  1  one-cycle strobe qualifying usb_report_i.
- event_o  output  9  FIFO head: [8] = 1 press / 0 release, [7:0] = HID usage code.
- event_valid_o  output  1  FIFO not empty.
- event_ready_i  input  1  pop; takes effect when event_valid_o=1.
- event_count_o  output  $clog2(FIFO_DEPTH)+1  events currently queued.
- busy_o  output  1  a scan is in progress; strobes arriving now are dropped.
- overflow_o  output  1  sticky: at least one event was dropped because the FIFO was full.
- clear_overflow_i  input  1  clears overflow_o.

Behaviour:
- Reset values: previous-report register = 0, FIFO empty, event_o = 0, event_valid_o = 0, event_count_o = 0, busy_o = 0, overflow_o = 0, FSM in IDLE.
- Reset asserted mid-scan aborts the scan; no partial update of the previous-report register.
- FSM states: IDLE, MOD, REL, PRS, COMMIT.
- IDLE:
  - On usb_report_valid_i, latch the report into cur.
  - If any key slot of cur equals 0x01 (ErrorRollOver), discard it: no events, previous unchanged, stay in IDLE.
  - Otherwise go to MOD with index i=0 and set busy_o=1 from the next cycle.
- MOD (8 cycles, i=0..7): if cur.byte0[i] != prev.byte0[i], push {cur.byte0[i], 8'hE0+i}.
- REL (6 cycles, slot s=2..7): if prev slot s is nonzero and not equal to any of the six cur key slots, push {0, prev slot s}. The six comparisons run in parallel within the cycle.
- PRS (6 cycles, slot s=2..7): if cur slot s is nonzero and not equal to any of the six prev key slots, push {1, cur slot s}.
- COMMIT (1 cycle): prev <= cur, busy_o <= 0, return to IDLE.
- Timing: a scan takes exactly 21 cycles from the cycle after the strobe. The first possible event is visible at event_valid_o 2 cycles after the strobe.
- usb_report_valid_i while busy_o=1 is ignored.
- Event order: modifiers (bit 0 first), then releases, then presses, each in ascending slot order.
- Duplicate usage codes within one report produce one event per qualifying slot; no dedupe.
- FIFO, push side:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is discarded and overflow_o is set.
- FIFO, pop side: a pop with an empty FIFO is a no-op.
- FIFO, count and pointers:
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FIFO, head visibility: event_o shows the head combinationally from the RAM/register array; a pushed event appears on the next cycle.
- Overflow clear vs. set: clear_overflow_i clears overflow_o on the next edge. If a drop happens in the same cycle, set wins.
- Scan is not stalled by a full FIFO; events are dropped.

Test Plan:
- Key press/release: reset; report {keys 0x04 in slot2} -> one event 0x104. Then an all-zero report -> event 0x004. Count 1 after each; pop empties.
- Modifier and ordering: prev = modifier 0x02 + key 0x05; new = modifier 0x01 + key 0x06. Required order: 0x1E0, 0x0E1, 0x005, 0x106.
- Rollover discard: a report with slot3 = 0x01 produces no events. A following report with no keys produces releases only for keys held before the rollover report.
- Overflow: FIFO_DEPTH=4, no pops. Press 6 distinct keys in one report -> count 4, overflow_o=1, head 0x104 (slot2 = 0x04). clear_overflow_i -> overflow_o=0.
- Full with concurrent pop: FIFO full, event_ready_i held high during a new scan -> no drops, overflow_o stays 0. A strobe during busy_o is ignored (no events from it).
- Async reset: assert reset_n_i mid-scan -> event_valid_o=0 immediately. Re-sending the previous report afterwards yields press events for all its keys.

Source files
------------

// File: rtl/usb_kbd_event_queue.sv
// Turns level-style HID boot-protocol keyboard reports into an edge-style stream
// of press/release events, buffered in a show-ahead FIFO for the SoC.
module usb_kbd_event_queue #(
   parameter int FIFO_DEPTH   = 16,
   parameter int REPORT_BYTES = 8,
   localparam int PtrW = $clog2(FIFO_DEPTH),
   localparam int CntW = PtrW + 1
) (
   input  logic                      clk,
   input  logic                      reset_n_i,
   input  logic [REPORT_BYTES*8-1:0] usb_report_i,
   input  logic                      usb_report_valid_i,
   output logic [8:0]                event_o,
   output logic                      event_valid_o,
   input  logic                      event_ready_i,
   output logic [CntW-1:0]           event_count_o,
   output logic                      busy_o,
   output logic                      overflow_o,
   input  logic                      clear_overflow_i
);

   if (REPORT_BYTES != 8) begin : gBadReportBytes
      $error("usb_kbd_event_queue: REPORT_BYTES must be 8 (boot protocol)");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : gBadDepth
      $error("usb_kbd_event_queue: FIFO_DEPTH must be a power of two, at least 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      MOD,
      REL,
      PRS,
      COMMIT
   } state_e;

   state_e          state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      curMod_q, curMod_d;
   logic [7:0]      prevMod_q, prevMod_d;
   logic [5:0][7:0] curKeys_q, curKeys_d;
   logic [5:0][7:0] prevKeys_q, prevKeys_d;

   logic [5:0][7:0] rptKeys;
   logic            rolloverSeen;
   logic            prevInCur;
   logic            curInPrev;
   logic            pushValid;
   logic [8:0]      pushData;

   logic [8:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] rdPtr_q, wrPtr_q;
   logic [CntW-1:0] count_q;
   logic            overflow_q;
   logic            popFire;
   logic            pushFire;
   logic            dropEvt;

   // The reserved byte carries no key information.
   logic unusedReserved;
   assign unusedReserved = ^usb_report_i[15:8];

   assign rptKeys = usb_report_i[63:16];

   always_comb begin
      rolloverSeen = 1'b0;
      for (int s = 0; s < 6; s++) begin
         if (rptKeys[s] == 8'h01) rolloverSeen = 1'b1;
      end
   end

   // Membership of the slot under scan in the other report, all six slots at once.
   always_comb begin
      prevInCur = 1'b0;
      curInPrev = 1'b0;
      for (int s = 0; s < 6; s++) begin
         if (curKeys_q[s] == prevKeys_q[idx_q]) prevInCur = 1'b1;
         if (prevKeys_q[s] == curKeys_q[idx_q]) curInPrev = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      curMod_d   = curMod_q;
      curKeys_d  = curKeys_q;
      prevMod_d  = prevMod_q;
      prevKeys_d = prevKeys_q;
      pushValid  = 1'b0;
      pushData   = 9'h000;
      unique case (state_q)
         IDLE: begin
            if (usb_report_valid_i) begin
               curMod_d  = usb_report_i[7:0];
               curKeys_d = rptKeys;
               if (!rolloverSeen) begin
                  state_d = MOD;
                  idx_d   = 3'd0;
               end
            end
         end
         MOD: begin
            if (curMod_q[idx_q] != prevMod_q[idx_q]) begin
               pushValid = 1'b1;
               pushData  = {curMod_q[idx_q], 8'hE0 + {5'b00000, idx_q}};
            end
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
               state_d = REL;
               idx_d   = 3'd0;
            end
         end
         REL: begin
            if ((prevKeys_q[idx_q] != 8'h00) && !prevInCur) begin
               pushValid = 1'b1;
               pushData  = {1'b0, prevKeys_q[idx_q]};
            end
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd5) begin
               state_d = PRS;
               idx_d   = 3'd0;
            end
         end
         PRS: begin
            if ((curKeys_q[idx_q] != 8'h00) && !curInPrev) begin
               pushValid = 1'b1;
               pushData  = {1'b1, curKeys_q[idx_q]};
            end
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd5) begin
               state_d = COMMIT;
               idx_d   = 3'd0;
            end
         end
         COMMIT: begin
            prevMod_d  = curMod_q;
            prevKeys_d = curKeys_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
            idx_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         idx_q      <= 3'd0;
         curMod_q   <= 8'h00;
         curKeys_q  <= '0;
         prevMod_q  <= 8'h00;
         prevKeys_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         curMod_q   <= curMod_d;
         curKeys_q  <= curKeys_d;
         prevMod_q  <= prevMod_d;
         prevKeys_q <= prevKeys_d;
      end
   end

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign popFire  = event_ready_i && (count_q != '0);
   assign pushFire = pushValid && ((count_q != CntW'(FIFO_DEPTH)) || popFire);
   assign dropEvt  = pushValid && !pushFire;

   always_ff @(posedge clk) begin
      if (pushFire) mem_q[wrPtr_q] <= pushData;
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (pushFire) wrPtr_q <= wrPtr_q + PtrW'(1);
         if (popFire)  rdPtr_q <= rdPtr_q + PtrW'(1);
         unique case ({pushFire, popFire})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: count_q <= count_q;
         endcase
         if (dropEvt) begin
            overflow_q <= 1'b1;
         end else if (clear_overflow_i) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign event_valid_o = (count_q != '0);
   assign event_o       = event_valid_o ? mem_q[rdPtr_q] : 9'h000;
   assign event_count_o = count_q;
   assign busy_o        = (state_q != IDLE);
   assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_usb_kbd_event_queue.sv
// Directed bench for usb_kbd_event_queue: a queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_usb_kbd_event_queue;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset_n_i;
   logic [63:0] usb_report_i;
   logic        usb_report_valid_i;
   logic [8:0]  event_o;
   logic        event_valid_o;
   logic        event_ready_i;
   logic [2:0]  event_count_o;
   logic        busy_o;
   logic        overflow_o;
   logic        clear_overflow_i;

   int nCompared   = 0;
   int nMismatched = 0;

   usb_kbd_event_queue #(.FIFO_DEPTH(DEPTH), .REPORT_BYTES(8)) dut (
      .clk               (clk),
      .reset_n_i         (reset_n_i),
      .usb_report_i      (usb_report_i),
      .usb_report_valid_i(usb_report_valid_i),
      .event_o           (event_o),
      .event_valid_o     (event_valid_o),
      .event_ready_i     (event_ready_i),
      .event_count_o     (event_count_o),
      .busy_o            (busy_o),
      .overflow_o        (overflow_o),
      .clear_overflow_i  (clear_overflow_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: queue of events, scan position (0 = idle, 1..21 = scan cycle)
   // and a per-scan-cycle schedule derived from the report difference rules.
   logic [8:0]  mq[$];
   int          scanPos;
   logic [63:0] mPrev, mCur;
   logic        mOvf;
   logic [8:0]  sched [22];
   logic        schedV [22];

   function automatic logic [7:0] keyOf(input logic [63:0] r, input int s);
      return r[16 + 8*s +: 8];
   endfunction

   function automatic logic inKeys(input logic [7:0] k, input logic [63:0] r);
      for (int s = 0; s < 6; s++) if (keyOf(r, s) == k) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [63:0] mk(input logic [7:0] m, input logic [7:0] k2 = 0,
                                      input logic [7:0] k3 = 0, input logic [7:0] k4 = 0,
                                      input logic [7:0] k5 = 0, input logic [7:0] k6 = 0,
                                      input logic [7:0] k7 = 0);
      return {k7, k6, k5, k4, k3, k2, 8'h00, m};
   endfunction

   task automatic modelReset();
      mq.delete();
      scanPos = 0;
      mPrev   = '0;
      mCur    = '0;
      mOvf    = 1'b0;
   endtask

   initial modelReset();
   always @(negedge reset_n_i) modelReset();

   always @(posedge clk) begin
      logic       dropNow;
      logic       rollover;
      logic [7:0] k;
      if (!reset_n_i) begin
         modelReset();
      end else begin
         dropNow = 1'b0;
         if (event_ready_i && mq.size() > 0) void'(mq.pop_front());
         if (scanPos > 0 && schedV[scanPos]) begin
            if (mq.size() < DEPTH) mq.push_back(sched[scanPos]);
            else dropNow = 1'b1;
         end
         if (dropNow) mOvf = 1'b1;
         else if (clear_overflow_i) mOvf = 1'b0;
         if (scanPos == 21) begin
            mPrev   = mCur;
            scanPos = 0;
         end else if (scanPos > 0) begin
            scanPos++;
         end else if (usb_report_valid_i) begin
            rollover = 1'b0;
            for (int s = 0; s < 6; s++) if (keyOf(usb_report_i, s) == 8'h01) rollover = 1'b1;
            if (!rollover) begin
               mCur = usb_report_i;
               for (int i = 0; i < 22; i++) begin
                  schedV[i] = 1'b0;
                  sched[i]  = 9'h000;
               end
               for (int i = 0; i < 8; i++) begin
                  if (mCur[i] != mPrev[i]) begin
                     schedV[1+i] = 1'b1;
                     sched[1+i]  = {mCur[i], 8'(8'hE0 + i)};
                  end
               end
               for (int s = 0; s < 6; s++) begin
                  k = keyOf(mPrev, s);
                  if (k != 8'h00 && !inKeys(k, mCur)) begin
                     schedV[9+s] = 1'b1;
                     sched[9+s]  = {1'b0, k};
                  end
                  k = keyOf(mCur, s);
                  if (k != 8'h00 && !inKeys(k, mPrev)) begin
                     schedV[15+s] = 1'b1;
                     sched[15+s]  = {1'b1, k};
                  end
               end
               scanPos = 1;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n_i) begin
         checkOutput("model valid", 32'(event_valid_o), 32'(mq.size() > 0));
         checkOutput("model count", 32'(event_count_o), 32'(mq.size()));
         checkOutput("model busy", 32'(busy_o), 32'(scanPos != 0));
         checkOutput("model overflow", 32'(overflow_o), 32'(mOvf));
         if (mq.size() > 0) checkOutput("model head", 32'(event_o), 32'(mq[0]));
      end
   end

   task automatic applyStimulus(input logic [63:0] r);
      @(negedge clk);
      usb_report_i       = r;
      usb_report_valid_i = 1'b1;
      @(negedge clk);
      usb_report_valid_i = 1'b0;
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic popCheck(input string name, input logic [8:0] exp);
      checkOutput(name, 32'(event_o), 32'(exp));
      event_ready_i = 1'b1;
      @(negedge clk);
      event_ready_i = 1'b0;
   endtask

   initial begin
      reset_n_i          = 1'b0;
      usb_report_i       = '0;
      usb_report_valid_i = 1'b0;
      event_ready_i      = 1'b0;
      clear_overflow_i   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset event_o", 32'(event_o), 32'h0);
      checkOutput("reset valid", 32'(event_valid_o), 32'h0);
      checkOutput("reset count", 32'(event_count_o), 32'h0);
      checkOutput("reset busy", 32'(busy_o), 32'h0);
      checkOutput("reset overflow", 32'(overflow_o), 32'h0);
      #1 reset_n_i = 1'b1;

      // Single key press then release
      applyStimulus(mk(8'h00, 8'h04));
      settle(21);
      checkOutput("t1 press count", 32'(event_count_o), 32'd1);
      popCheck("t1 press head", 9'h104);
      checkOutput("t1 popped count", 32'(event_count_o), 32'd0);
      applyStimulus(mk(8'h00));
      settle(21);
      checkOutput("t1 release count", 32'(event_count_o), 32'd1);
      popCheck("t1 release head", 9'h004);
      checkOutput("t1 empty", 32'(event_valid_o), 32'd0);

      // Modifier and ordering
      applyStimulus(mk(8'h02, 8'h05));
      settle(21);
      popCheck("t2 setup mod", 9'h1E1);
      popCheck("t2 setup key", 9'h105);
      applyStimulus(mk(8'h01, 8'h06));
      settle(21);
      checkOutput("t2 count", 32'(event_count_o), 32'd4);
      popCheck("t2 ev0", 9'h1E0);
      popCheck("t2 ev1", 9'h0E1);
      popCheck("t2 ev2", 9'h005);
      popCheck("t2 ev3", 9'h106);

      // Rollover report is discarded
      applyStimulus(mk(8'h01, 8'h06, 8'h01));
      checkOutput("t3 rollover busy", 32'(busy_o), 32'd0);
      settle(21);
      checkOutput("t3 rollover count", 32'(event_count_o), 32'd0);
      applyStimulus(mk(8'h00));
      settle(21);
      checkOutput("t3 release count", 32'(event_count_o), 32'd2);
      popCheck("t3 rel mod", 9'h0E0);
      popCheck("t3 rel key", 9'h006);

      // Overflow with no pops
      applyStimulus(mk(8'h00, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
      settle(21);
      checkOutput("t4 count", 32'(event_count_o), 32'd4);
      checkOutput("t4 overflow", 32'(overflow_o), 32'd1);
      checkOutput("t4 head", 32'(event_o), 32'h104);
      clear_overflow_i = 1'b1;
      @(negedge clk);
      clear_overflow_i = 1'b0;
      checkOutput("t4 cleared", 32'(overflow_o), 32'd0);

      // Full FIFO with concurrent pops, and a strobe while busy
      applyStimulus(mk(8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
      event_ready_i = 1'b1;
      settle(3);
      checkOutput("t5 full while popping", 32'(event_count_o), 32'd4);
      usb_report_i       = mk(8'h00, 8'h20);
      usb_report_valid_i = 1'b1;
      @(negedge clk);
      usb_report_valid_i = 1'b0;
      settle(25);
      checkOutput("t5 drained", 32'(event_count_o), 32'd0);
      checkOutput("t5 no overflow", 32'(overflow_o), 32'd0);
      checkOutput("t5 idle", 32'(busy_o), 32'd0);
      event_ready_i = 1'b0;

      // Asynchronous reset mid-scan
      applyStimulus(mk(8'h00, 8'h0A));
      settle(4);
      checkOutput("t6 pre-reset valid", 32'(event_valid_o), 32'd1);
      @(posedge clk);
      #2 reset_n_i = 1'b0;
      #1;
      checkOutput("t6 reset valid", 32'(event_valid_o), 32'd0);
      checkOutput("t6 reset busy", 32'(busy_o), 32'd0);
      checkOutput("t6 reset count", 32'(event_count_o), 32'd0);
      settle(2);
      #1 reset_n_i = 1'b1;
      applyStimulus(mk(8'hFF, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09));
      @(negedge clk);
      checkOutput("t6 first press", 32'(event_o), 32'h1E0);
      event_ready_i = 1'b1;
      settle(25);
      checkOutput("t6 drained", 32'(event_count_o), 32'd0);
      checkOutput("t6 no overflow", 32'(overflow_o), 32'd0);
      event_ready_i = 1'b0;
      settle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: got no finish, expected finish");
      $fatal(1, "[TB] timeout");
   end

endmodule
